// File: rtl/alarm_trigger.sv
// Alarm sequencer: rings on a time match, handles snooze/stop/timeout and
// drives buzzer, blink pattern, state and snooze count from registers.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | armed, waiting for tick_1s with a matching time
// RINGING  | buzzer on, led blinks each second, ring timer running
// SNOOZE   | buzzer off, snooze timer running until the next ring
// DONE     | event finished, waits for stop release and the minute to pass
module alarm_trigger #(
    parameter int RING_SECS  = 60,
    parameter int SNOOZE_MIN = 5,
    parameter int MAX_SNOOZE = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1s,
    input  logic [5:0] hour,
    input  logic [5:0] minute,
    input  logic [5:0] second,
    input  logic [5:0] alarm_hour,
    input  logic [5:0] alarm_minute,
    input  logic       alarm_en,
    input  logic       stop,
    input  logic       snooze,
    output logic       ring,
    output logic [9:0] led,
    output logic [1:0] state,
    output logic [2:0] snooze_cnt
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RINGING = 2'd1,
        S_SNOOZE  = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [6:0] RING_TC   = 7'(RING_SECS);
    localparam logic [9:0] SNOOZE_TC = 10'(SNOOZE_MIN * 60);
    localparam logic [2:0] MAX_SC    = 3'(MAX_SNOOZE);
    localparam logic [9:0] LED_ENTRY = 10'b0101010101;

    state_t     state_q, state_d;
    logic [6:0] sec_q, sec_d;
    logic [9:0] snz_q, snz_d;
    logic [9:0] led_q, led_d;
    logic [2:0] sc_q, sc_d;
    logic       ring_q, ring_d;

    logic       match;
    logic       snooze_left;
    logic [6:0] sec_inc;
    logic [9:0] snz_inc;

    assign match       = alarm_en && (hour == alarm_hour) && (minute == alarm_minute)
                         && (second == 6'd0);
    assign snooze_left = (sc_q < MAX_SC);
    assign sec_inc     = sec_q + 7'd1;
    assign snz_inc     = snz_q + 10'd1;

    always_comb begin
        state_d = state_q;
        sec_d   = sec_q;
        snz_d   = snz_q;
        led_d   = led_q;
        sc_d    = sc_q;

        if (!alarm_en) begin
            state_d = S_IDLE;
            sec_d   = '0;
            snz_d   = '0;
            sc_d    = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (tick_1s && match) begin
                        state_d = S_RINGING;
                        sec_d   = '0;
                        led_d   = LED_ENTRY;
                    end
                end
                S_RINGING: begin
                    if (stop) begin
                        state_d = S_DONE;
                    end else if (snooze && snooze_left) begin
                        state_d = S_SNOOZE;
                        sc_d    = sc_q + 3'd1;
                        snz_d   = '0;
                    end else if (tick_1s) begin
                        led_d = ~led_q;
                        sec_d = sec_inc;
                        // Ring timeout snoozes while snoozes remain, else ends the event
                        if (sec_inc == RING_TC) begin
                            if (snooze_left) begin
                                state_d = S_SNOOZE;
                                sc_d    = sc_q + 3'd1;
                                snz_d   = '0;
                            end else begin
                                state_d = S_DONE;
                            end
                        end
                    end
                end
                S_SNOOZE: begin
                    if (stop) begin
                        state_d = S_DONE;
                    end else if (tick_1s) begin
                        snz_d = snz_inc;
                        if (snz_inc == SNOOZE_TC) begin
                            state_d = S_RINGING;
                            sec_d   = '0;
                            snz_d   = '0;
                            led_d   = LED_ENTRY;
                        end
                    end
                end
                S_DONE: begin
                    if (!stop && ({hour, minute} != {alarm_hour, alarm_minute})) begin
                        state_d = S_IDLE;
                        sec_d   = '0;
                        snz_d   = '0;
                        sc_d    = '0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        ring_d = (state_d == S_RINGING);
        if (state_d != S_RINGING) begin
            led_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            sec_q   <= '0;
            snz_q   <= '0;
            led_q   <= '0;
            sc_q    <= '0;
            ring_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sec_q   <= sec_d;
            snz_q   <= snz_d;
            led_q   <= led_d;
            sc_q    <= sc_d;
            ring_q  <= ring_d;
        end
    end

    assign ring       = ring_q;
    assign led        = led_q;
    assign state      = state_q;
    assign snooze_cnt = sc_q;

endmodule
